mem_cascade_unshifter: RTL and testbench

// Response-path counterpart of the request-side port rotator. Requests from NrPorts

---
 rtl/mem_cascade_unshifter.sv | 105 ++++++++++
 tb/tb_mem_cascade_unshifter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_cascade_unshifter.sv
// Response-path unshifter: tracks per-cycle request masks and rotation amounts for MemoryLatency
// cycles, then routes bank responses back to their initiator ports through a log2 rotation cascade.
module mem_cascade_unshifter #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NrPorts       = 8,
    parameter int unsigned MemoryLatency = 1,
    parameter int unsigned RegisterRsp   = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NrPorts-1:0]             req_fire_i,
    input  logic [$clog2(NrPorts)-1:0]     sel_i,
    input  logic [NrPorts*DataWidth-1:0]   bank_rdata_i,
    output logic [NrPorts-1:0]             rsp_valid_o,
    output logic [NrPorts*DataWidth-1:0]   rsp_rdata_o,
    output logic                           idle_o
);

    localparam int unsigned SelWidth = $clog2(NrPorts);

    typedef logic [SelWidth-1:0]  sel_t;
    typedef logic [NrPorts-1:0]   mask_t;
    typedef logic [DataWidth-1:0] word_t;

    mask_t mask_q [MemoryLatency];
    sel_t  sel_q  [MemoryLatency];

    // NOTE: the tracking stages are a small shift pipeline, not a RAM, so every stage is reset;
    // this is what drops in-flight responses when rst_ni asserts mid-traffic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MemoryLatency); i++) begin
                mask_q[i] <= '0;
                sel_q[i]  <= '0;
            end
        end else begin
            mask_q[0] <= req_fire_i;
            sel_q[0]  <= sel_i;
            for (int i = 1; i < int'(MemoryLatency); i++) begin
                mask_q[i] <= mask_q[i-1];
                sel_q[i]  <= sel_q[i-1];
            end
        end
    end

    mask_t last_mask;
    sel_t  last_sel;
    assign last_mask = mask_q[MemoryLatency-1];
    assign last_sel  = sel_q[MemoryLatency-1];

    // Level k pulls from port (p + 2^k) mod NrPorts, so the full cascade yields bank (p + sel).
    word_t level [SelWidth+1][NrPorts];

    for (genvar p = 0; p < NrPorts; p++) begin : g_level0
        assign level[0][p] = bank_rdata_i[p*DataWidth +: DataWidth];
    end

    for (genvar k = 0; k < SelWidth; k++) begin : g_cascade
        for (genvar p = 0; p < NrPorts; p++) begin : g_port
            localparam int unsigned Src = (p + (1 << k)) % NrPorts;
            assign level[k+1][p] = last_sel[k] ? level[k][Src] : level[k][p];
        end
    end

    logic [NrPorts*DataWidth-1:0] rsp_rdata_comb;

    for (genvar p = 0; p < NrPorts; p++) begin : g_gate
        assign rsp_rdata_comb[p*DataWidth +: DataWidth] =
            last_mask[p] ? level[SelWidth][p] : '0;
    end

    logic out_busy;

    if (RegisterRsp != 0) begin : g_reg
        mask_t                        valid_q;
        logic [NrPorts*DataWidth-1:0] rdata_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= '0;
                rdata_q <= '0;
            end else begin
                valid_q <= last_mask;
                rdata_q <= rsp_rdata_comb;
            end
        end

        assign rsp_valid_o = valid_q;
        assign rsp_rdata_o = rdata_q;
        assign out_busy    = |valid_q;
    end else begin : g_comb
        assign rsp_valid_o = last_mask;
        assign rsp_rdata_o = rsp_rdata_comb;
        assign out_busy    = 1'b0;
    end

    // Idle is derived purely from flops so it is glitch-free against the request inputs.
    always_comb begin
        idle_o = !out_busy;
        for (int i = 0; i < int'(MemoryLatency); i++) begin
            if (|mask_q[i]) idle_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_cascade_unshifter.sv
// Scoreboard bench for mem_cascade_unshifter: three configurations share one random stimulus
// stream; expected responses are computed from the rotation rule at issue time.
module tb_mem_cascade_unshifter;

    localparam int N    = 8;
    localparam int W    = 32;
    localparam int SW   = 3;
    localparam int ND   = 3;
    localparam int NCYC = 400;
    localparam int RC   = 200;

    function automatic int lat_of(input int d);
        case (d)
            0: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int rr_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    typedef struct {
        int              due;
        logic [N-1:0]    valid;
        logic [N*W-1:0]  data;
    } exp_t;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [N-1:0]   req_fire_i;
    logic [SW-1:0]  sel_i;
    logic [N*W-1:0] bank_rdata_i;

    logic [N-1:0]   rsp_valid [ND];
    logic [N*W-1:0] rsp_rdata [ND];
    logic           idle      [ND];

    logic [N-1:0]   fire_hist [NCYC+8];
    logic [SW-1:0]  sel_hist  [NCYC+8];
    logic [N*W-1:0] bank_hist [NCYC+8];

    exp_t sb [ND][$];
    int   cyc     = 0;
    bit   running = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    mem_cascade_unshifter #(.DataWidth(W), .NrPorts(N), .MemoryLatency(2), .RegisterRsp(0)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_fire_i(req_fire_i), .sel_i(sel_i),
        .bank_rdata_i(bank_rdata_i), .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]),
        .idle_o(idle[0]));

    mem_cascade_unshifter #(.DataWidth(W), .NrPorts(N), .MemoryLatency(1), .RegisterRsp(1)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_fire_i(req_fire_i), .sel_i(sel_i),
        .bank_rdata_i(bank_rdata_i), .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]),
        .idle_o(idle[1]));

    mem_cascade_unshifter #(.DataWidth(W), .NrPorts(N), .MemoryLatency(1), .RegisterRsp(0)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_fire_i(req_fire_i), .sel_i(sel_i),
        .bank_rdata_i(bank_rdata_i), .rsp_valid_o(rsp_valid[2]), .rsp_rdata_o(rsp_rdata[2]),
        .idle_o(idle[2]));

    task automatic check(input string nm, input int d, input logic [N*W-1:0] act,
                         input logic [N*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, d, cyc, act, exp);
        end
    endtask

    // Expected response: port p receives the word bank (p+sel)%N drove at the response cycle.
    function automatic exp_t make_exp(input int c, input int d);
        exp_t e;
        int   rc;
        int   b;
        rc      = c + lat_of(d);
        e.due   = rc + rr_of(d);
        e.valid = fire_hist[c];
        e.data  = '0;
        for (int p = 0; p < N; p++) begin
            if (fire_hist[c][p]) begin
                b = (p + int'(sel_hist[c])) % N;
                e.data[p*W +: W] = bank_hist[rc][b*W +: W];
            end
        end
        return e;
    endfunction

    // Monitor: one pop per due cycle, otherwise the outputs must be quiet.
    always @(negedge clk_i) begin
        if (running && rst_ni) begin
            for (int d = 0; d < ND; d++) begin
                exp_t e;
                bit   busy;
                e.due   = cyc;
                e.valid = '0;
                e.data  = '0;
                busy    = 1'b0;
                if (sb[d].size() > 0 && sb[d][0].due == cyc) begin
                    e    = sb[d].pop_front();
                    busy = 1'b1;
                end
                if (sb[d].size() > 0 && sb[d][0].due < cyc + lat_of(d) + rr_of(d))
                    busy = 1'b1;
                check("rsp_valid", d, {{(N*W-N){1'b0}}, rsp_valid[d]}, {{(N*W-N){1'b0}}, e.valid});
                check("rsp_rdata", d, rsp_rdata[d], e.data);
                check("idle", d, {{(N*W-1){1'b0}}, idle[d]}, {{(N*W-1){1'b0}}, !busy});
            end
        end
    end

    initial begin
        for (int c = 0; c < NCYC + 8; c++) begin
            fire_hist[c] = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            sel_hist[c]  = SW'($urandom);
            for (int b = 0; b < N; b++) bank_hist[c][b*W +: W] = $urandom;
        end
        // Single-port, no rotation.
        fire_hist[2] = 8'h01; sel_hist[2] = 3'd0;
        bank_hist[3][31:0] = 32'h0000_00A5;
        bank_hist[4][31:0] = 32'h0000_00A5;
        // Wrap-around: port 5 with sel 3 reads bank 0.
        fire_hist[6] = 8'h20; sel_hist[6] = 3'd3;
        // Back-to-back full-width with different rotations.
        fire_hist[10] = 8'hFF; sel_hist[10] = 3'd1;
        fire_hist[11] = 8'hFF; sel_hist[11] = 3'd6;
        // Idle window with garbage on the banks.
        for (int c = 12; c <= 20; c++) fire_hist[c] = '0;
        for (int c = 15; c <= 20; c++) bank_hist[c] = {N{32'h0000_DEAD}};
        // Top port with sel 7 reads bank 6.
        fire_hist[25] = 8'h80; sel_hist[25] = 3'd7;
        // Traffic in flight when reset hits.
        fire_hist[RC-1] = 8'h0F; fire_hist[RC] = 8'h0F;
        for (int c = NCYC - 8; c < NCYC; c++) fire_hist[c] = '0;

        rst_ni       = 1'b0;
        req_fire_i   = '0;
        sel_i        = '0;
        bank_rdata_i = {N{32'h0000_DEAD}};
        repeat (3) @(posedge clk_i);
        #1;
        for (int d = 0; d < ND; d++) begin
            check("reset_valid", d, {{(N*W-N){1'b0}}, rsp_valid[d]}, '0);
            check("reset_rdata", d, rsp_rdata[d], '0);
            check("reset_idle", d, {{(N*W-1){1'b0}}, idle[d]}, 1);
        end
        rst_ni = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk_i);
            #1;
            cyc = c;
            if (c == RC + 1) rst_ni = 1'b1;
            req_fire_i   = fire_hist[c];
            sel_i        = sel_hist[c];
            bank_rdata_i = bank_hist[c];
            running      = 1'b1;
            if (c == RC) begin
                #1 rst_ni = 1'b0;
                #1;
                for (int d = 0; d < ND; d++) begin
                    check("midrst_valid", d, {{(N*W-N){1'b0}}, rsp_valid[d]}, '0);
                    check("midrst_rdata", d, rsp_rdata[d], '0);
                    check("midrst_idle", d, {{(N*W-1){1'b0}}, idle[d]}, 1);
                    sb[d].delete();
                end
            end else if (fire_hist[c] != '0) begin
                for (int d = 0; d < ND; d++) sb[d].push_back(make_exp(c, d));
            end
        end

        @(posedge clk_i);
        #1;
        running = 1'b0;
        for (int d = 0; d < ND; d++)
            check("drain", d, N*W'(sb[d].size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
